// File: rtl/alu_sequencer.sv
// Micro-instruction sequencer driving the ALU control strobes over a valid/ready handshake.
// Optional: define ALU_SEQ_SIGNED_COND_EN to evaluate condition codes 110 (V) and 111 (N^V).
module alu_sequencer (
  input  logic       i_clk,
  input  logic       i_nReset,
  input  logic       i_instrValid,
  input  logic [7:0] i_instr,
  output logic       o_instrReady,
  input  logic       i_flagNegative,
  input  logic       i_flagZero,
  input  logic       i_flagOverflow,
  input  logic       i_flagCarry,
  output logic       o_ctrlAluYNWE,
  output logic       o_ctrlAluNOE,
  output logic       o_ctrlAluSub,
  output logic [1:0] o_ctrlAluOp,
  output logic       o_writeStrobe,
  output logic       o_branchTaken,
  output logic       o_done
);

  typedef enum logic [2:0] {IDLE, EXEC, WRITE, EVAL, FIN} state_t;
  typedef enum logic [1:0] {CLS_ALU = 2'b00, CLS_CMP = 2'b01, CLS_BR = 2'b10, CLS_NOP = 2'b11} class_t;

  state_t     state, nextState;
  class_t     instrClass;
  logic [1:0] instrOp;
  logic       instrSub;
  logic       accept;
  logic       condTrue;

  // Flags are stable from the accepting edge through EVAL (nothing latches them in between),
  // so evaluating at accept lets the branch result leave a register during EVAL.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    condTrue = 1'b0;
    case (i_instr[2:0])
      3'b000:  condTrue = 1'b1;
      3'b001:  condTrue = i_flagZero;
      3'b010:  condTrue = !i_flagZero;
      3'b011:  condTrue = i_flagCarry;
      3'b100:  condTrue = !i_flagCarry;
      3'b101:  condTrue = i_flagNegative;
`ifdef ALU_SEQ_SIGNED_COND_EN
      3'b110:  condTrue = i_flagOverflow;
      3'b111:  condTrue = i_flagNegative ^ i_flagOverflow;
`endif
      default: condTrue = 1'b0;
    endcase
  end

`ifndef ALU_SEQ_SIGNED_COND_EN
  logic unusedOverflow;
  assign unusedOverflow = i_flagOverflow;
`endif

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        accept = i_instrValid && o_instrReady;
        if (accept) begin
          case (class_t'(i_instr[7:6]))
            CLS_ALU, CLS_CMP: nextState = EXEC;
            CLS_BR:           nextState = EVAL;
            default:          nextState = FIN;
          endcase
        end
      end
      EXEC:    nextState = (instrClass == CLS_ALU) ? WRITE : FIN;
      WRITE:   nextState = IDLE;
      EVAL:    nextState = IDLE;
      FIN:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs are registered copies of the decode of the next state.
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      state         <= IDLE;
      instrClass    <= CLS_ALU;
      instrOp       <= 2'b00;
      instrSub      <= 1'b0;
      o_instrReady  <= 1'b1;
      o_ctrlAluYNWE <= 1'b1;
      o_ctrlAluNOE  <= 1'b1;
      o_writeStrobe <= 1'b0;
      o_branchTaken <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state         <= nextState;
      o_instrReady  <= (nextState == IDLE);
      o_ctrlAluYNWE <= (nextState != EXEC);
      o_ctrlAluNOE  <= (nextState != WRITE);
      o_writeStrobe <= (nextState == WRITE);
      o_branchTaken <= (nextState == EVAL) && condTrue;
      o_done        <= (nextState == WRITE) || (nextState == EVAL) || (nextState == FIN);
      if (accept) begin
        instrClass <= class_t'(i_instr[7:6]);
        instrOp    <= i_instr[5:4];
        instrSub   <= i_instr[3];
      end
    end
  end

  // Op/sub simply hold the last latched fields; only the strobes are state-gated.
  assign o_ctrlAluOp  = instrOp;
  assign o_ctrlAluSub = instrSub;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Control-side counterpart of the ALU datapath: accepts one 8-bit micro-instruction at a time over a valid/ready handshake and drives the ALU control strobes (compute/latch, bus output enable, subtract, op select) cycle by cycle. It also reads back the four registered ALU flags to evaluate conditional branches. It sits between the instruction decoder and the ALU, replacing hard-wired strobe generation.

## Interface
- No parameters.
- i_clk  in  1  system clock, all state on rising edge
- i_nReset  in  1  asynchronous, active-low reset
- i_instrValid  in  1  instruction present on i_instr
- i_instr  in  8  [7:6] class, [5:4] ALU op, [3] sub, [2:0] condition code
- o_instrReady  out  1  sequencer can accept an instruction
- i_flagNegative, i_flagZero, i_flagOverflow, i_flagCarry  in  1 each  registered ALU flags
- o_ctrlAluYNWE  out  1  active-low ALU result/flag latch strobe
- o_ctrlAluNOE  out  1  active-low ALU bus output enable
- o_ctrlAluSub  out  1  subtract / reverse-shift select
- o_ctrlAluOp  out  2  00 add, 01 and, 10 xor, 11 shift
- o_writeStrobe  out  1  destination-register write, coincident with o_ctrlAluNOE low
- o_branchTaken  out  1  one-cycle pulse, branch condition true
- o_done  out  1  one-cycle pulse on final cycle of every instruction

## Operation
- Classes: 00 ALU (compute + write back), 01 compare (compute, flags only), 10 branch (evaluate flags), 11 NOP.
- States: IDLE, EXEC, WRITE, EVAL, FIN.
- IDLE: o_instrReady=1. i_instrValid && o_instrReady latches i_instr; next state EXEC for classes 00/01, EVAL for class 10, FIN for class 11.
- EXEC: o_ctrlAluYNWE=0, o_ctrlAluOp/o_ctrlAluSub from latched fields. Next: WRITE (class 00) or FIN (class 01).
- WRITE: o_ctrlAluNOE=0, o_writeStrobe=1, o_done=1. Next IDLE.
- EVAL: samples flags; o_branchTaken=condition; o_done=1. Next IDLE.
- FIN: o_done=1, no strobes. Next IDLE.
- Condition codes: 000 always, 001 Z, 010 !Z, 011 C, 100 !C, 101 N, 110 V, 111 N^V (signed less-than).
- o_ctrlAluOp/o_ctrlAluSub hold the last latched values outside EXEC; only strobes are state-gated.
- All outputs registered (decoded from next state); no combinational input-to-output path.

## Timing
- Reset (async assert, sync release): state IDLE, o_instrReady=1, o_ctrlAluYNWE=1, o_ctrlAluNOE=1, o_ctrlAluSub=0, o_ctrlAluOp=00, o_writeStrobe=0, o_branchTaken=0, o_done=0, latched instr=0.
- Accept at edge N. ALU: EXEC in cycle N+1, WRITE+o_done in N+2. Compare: EXEC N+1, FIN N+2. Branch: EVAL N+1. NOP: FIN N+1.
- o_instrReady low from the cycle after accept until IDLE is re-entered; back-to-back throughput: ALU one per 3 cycles, branch/NOP one per 2.
- i_instr ignored while o_instrReady=0; valid may stay high without effect.
- EVAL uses flags as present during EVAL; a branch immediately after a compare sees flags updated at the end of that compare's EXEC.
- Reset mid-instruction: strobes return to inactive immediately, no o_done, no o_writeStrobe; instruction is dropped.

## Configuration
- ALU_SEQ_SIGNED_COND_EN defined: condition codes 110 (V) and 111 (N^V) evaluated as above.
- Not defined: codes 110/111 never taken (o_branchTaken=0, o_done still pulses); i_flagOverflow unused.

## Test plan
- Reset released, no valid -> all outputs at reset values, o_instrReady=1 indefinitely.
- i_instr=0x08 (ALU add, sub=1) accepted at edge N -> o_ctrlAluYNWE=0, o_ctrlAluSub=1, Op=00 in N+1; o_ctrlAluNOE=0, o_writeStrobe=1, o_done=1 in N+2; ready=1 in N+3.
- i_instr=0x48 (compare) then 0x81 (branch Z) with flags Zero=1 after compare -> no NOE/write pulse; o_branchTaken=1 on EVAL; same with Zero=0 -> o_branchTaken=0, o_done=1.
- Branch 0x87 with N=1, V=0 -> taken with ALU_SEQ_SIGNED_COND_EN, not taken without; N=1,V=1 -> not taken either way.
- i_instr=0xC0 (NOP) with valid held high continuously -> o_done every 2 cycles, no strobes ever low.
- i_nReset pulled low during EXEC of 0x30 (shift) -> o_ctrlAluYNWE=1 asynchronously; after release state IDLE, no o_done/o_writeStrobe for that instruction.
